// File: rtl/fiber_dram_port.sv
// Memory-side adapter between a fiber cache bank and the DRAM crossbar: in-order
// request queue, single registered command slot, credit-reserved fill response buffer.
module fiber_dram_port #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned REQ_DEPTH  = 4,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_nreset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [ADDR_WIDTH-1:0] o_resp_addr,
    output logic [DATA_WIDTH-1:0] o_resp_data,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_busy,
    output logic                  o_err
);
    localparam int unsigned QAW = $clog2(REQ_DEPTH);
    localparam int unsigned QPW = QAW + 1;
    localparam int unsigned RAW = $clog2(RESP_DEPTH);
    localparam int unsigned RPW = RAW + 1;
    localparam int unsigned CW  = RAW + 1;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } resp_t;

    req_t                  q_mem  [REQ_DEPTH];
    logic [ADDR_WIDTH-1:0] pa_mem [RESP_DEPTH];
    resp_t                 rs_mem [RESP_DEPTH];

    logic [QPW-1:0] q_wr, q_rd;
    logic [RPW-1:0] pa_wr, pa_rd, rs_wr, rs_rd;
    logic [CW-1:0]  credits;

    logic  q_empty, q_full, q_push;
    logic  pa_empty, rs_empty;
    logic  slot_free, load, load_read, rd_accept, resp_pop, rv_ok, rv_bad;
    req_t  q_head;
    resp_t rs_head;

    // Handshake and issue decisions
    always_comb begin
        q_empty   = (q_wr == q_rd);
        q_full    = (q_wr[QAW] != q_rd[QAW]) && (q_wr[QAW-1:0] == q_rd[QAW-1:0]);
        pa_empty  = (pa_wr == pa_rd);
        rs_empty  = (rs_wr == rs_rd);
        q_head    = q_mem[q_rd[QAW-1:0]];
        rs_head   = rs_mem[rs_rd[RAW-1:0]];
        q_push    = i_req_valid & ~q_full;
        slot_free = ~(o_mem_read | o_mem_write) | i_mem_ready;
        load      = slot_free & ~q_empty & (q_head.write | (credits < CW'(RESP_DEPTH)));
        load_read = load & ~q_head.write;
        rd_accept = o_mem_read & i_mem_ready;
        resp_pop  = ~rs_empty & i_resp_ready;
        rv_ok     = i_mem_rvalid & ~pa_empty;
        rv_bad    = i_mem_rvalid & pa_empty;
    end

    assign o_req_ready  = ~q_full;
    assign o_resp_valid = ~rs_empty;
    assign o_resp_addr  = rs_head.addr;
    assign o_resp_data  = rs_head.data;
    assign o_busy       = ~q_empty | o_mem_read | o_mem_write | (credits != '0);

    // FIFO storage needs no reset; occupancy lives in the pointers
    always_ff @(posedge i_clk) begin
        if (q_push)    q_mem[q_wr[QAW-1:0]]   <= '{write: i_req_write, addr: i_req_addr, wdata: i_req_wdata};
        if (rd_accept) pa_mem[pa_wr[RAW-1:0]] <= o_mem_addr;
        if (rv_ok)     rs_mem[rs_wr[RAW-1:0]] <= '{addr: pa_mem[pa_rd[RAW-1:0]], data: i_mem_rdata};
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            q_wr        <= '0;
            q_rd        <= '0;
            pa_wr       <= '0;
            pa_rd       <= '0;
            rs_wr       <= '0;
            rs_rd       <= '0;
            credits     <= '0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_err       <= 1'b0;
        end else begin
            if (q_push)    q_wr  <= q_wr + QPW'(1);
            if (load)      q_rd  <= q_rd + QPW'(1);
            if (rd_accept) pa_wr <= pa_wr + RPW'(1);
            if (rv_ok)     pa_rd <= pa_rd + RPW'(1);
            if (rv_ok)     rs_wr <= rs_wr + RPW'(1);
            if (resp_pop)  rs_rd <= rs_rd + RPW'(1);
            if (rv_bad)    o_err <= 1'b1;

            // Credit reserves a response slot from read issue until the fill is handed off
            if (load_read && !resp_pop)      credits <= credits + CW'(1);
            else if (!load_read && resp_pop) credits <= credits - CW'(1);

            if (load) begin
                o_mem_read  <= ~q_head.write;
                o_mem_write <= q_head.write;
                o_mem_addr  <= q_head.addr;
                o_mem_wdata <= q_head.wdata;
            end else if (slot_free) begin
                o_mem_read  <= 1'b0;
                o_mem_write <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fiber_dram_port.sv
// Directed self-checking bench for fiber_dram_port with default parameters.
module tb_fiber_dram_port;
    logic        i_clk = 1'b0;
    logic        i_nreset = 1'b0;
    logic        i_req_valid = 1'b0, i_req_write = 1'b0;
    logic [63:0] i_req_addr = '0;
    logic [15:0] i_req_wdata = '0;
    logic        o_req_ready, o_resp_valid;
    logic        i_resp_ready = 1'b0;
    logic [63:0] o_resp_addr, o_mem_addr;
    logic [15:0] o_resp_data, o_mem_wdata;
    logic        o_mem_read, o_mem_write;
    logic        i_mem_ready = 1'b0, i_mem_rvalid = 1'b0;
    logic [15:0] i_mem_rdata = '0;
    logic        o_busy, o_err;

    int passed = 0;
    int total  = 0;
    int acc_cnt = 0;

    fiber_dram_port dut (
        .i_clk(i_clk), .i_nreset(i_nreset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_addr(o_resp_addr), .o_resp_data(o_resp_data),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    // Counts DRAM read acceptances, sampled mid-cycle
    always @(negedge i_clk) if (o_mem_read && i_mem_ready) acc_cnt <= acc_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge i_clk); #1;
    endtask

    task automatic push_req(input logic w, input logic [63:0] a, input logic [15:0] d, output bit ok);
        int n = 0;
        ok = 1'b0;
        i_req_valid = 1'b1; i_req_write = w; i_req_addr = a; i_req_wdata = d;
        while (!ok && n < 50) begin
            if (o_req_ready) ok = 1'b1;
            tick(); n++;
        end
        i_req_valid = 1'b0;
    endtask

    task automatic wait_acc(input int target, output bit ok);
        int n = 0;
        while (acc_cnt < target && n < 100) begin tick(); n++; end
        ok = (acc_cnt >= target);
    endtask

    task automatic send_rdata(input logic [15:0] d);
        i_mem_rvalid = 1'b1; i_mem_rdata = d;
        tick();
        i_mem_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        total++; if ({o_req_ready, o_resp_valid, o_mem_read, o_mem_write, o_busy, o_err} !== 6'b100000)
            $display("FAIL reset_flags got=%b exp=100000", {o_req_ready, o_resp_valid, o_mem_read, o_mem_write, o_busy, o_err}); else passed++;
        total++; if ({o_mem_addr, o_mem_wdata} !== 80'h0)
            $display("FAIL reset_cmd got=%h exp=0", {o_mem_addr, o_mem_wdata}); else passed++;
        repeat (2) @(posedge i_clk);
        #3 i_nreset = 1'b1;
        tick();
        total++; if ({o_req_ready, o_busy} !== 2'b10)
            $display("FAIL reset_release got=%b exp=10", {o_req_ready, o_busy}); else passed++;
    endtask

    task automatic test_single_fill;
        bit ok;
        i_mem_ready = 1'b1; i_resp_ready = 1'b0;
        push_req(1'b0, 64'h1000, 16'h0, ok);
        tick();
        total++; if ({o_mem_read, o_mem_write, o_mem_addr} !== {2'b10, 64'h1000})
            $display("FAIL fill_cmd got=%b%b/%h exp=10/1000", o_mem_read, o_mem_write, o_mem_addr); else passed++;
        tick();
        total++; if ({o_mem_read, o_busy, o_resp_valid} !== 3'b010)
            $display("FAIL fill_accepted got=%b exp=010", {o_mem_read, o_busy, o_resp_valid}); else passed++;
        tick(); tick();
        send_rdata(16'hBEEF);
        total++; if ({o_resp_valid, o_resp_addr, o_resp_data} !== {1'b1, 64'h1000, 16'hBEEF})
            $display("FAIL fill_resp got=%b/%h/%h exp=1/1000/beef", o_resp_valid, o_resp_addr, o_resp_data); else passed++;
        total++; if (o_busy !== 1'b1) $display("FAIL fill_busy_held got=%b exp=1", o_busy); else passed++;
        i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;
        total++; if ({o_resp_valid, o_busy, o_err} !== 3'b000)
            $display("FAIL fill_done got=%b exp=000", {o_resp_valid, o_busy, o_err}); else passed++;
    endtask

    task automatic test_order;
        bit ok;
        logic [63:0] exp_a;
        i_mem_ready = 1'b0; i_resp_ready = 1'b0;
        push_req(1'b1, 64'h20, 16'h1111, ok);
        push_req(1'b0, 64'h40, 16'h0, ok);
        total++; if ({o_mem_write, o_mem_read, o_mem_addr, o_mem_wdata} !== {2'b10, 64'h20, 16'h1111})
            $display("FAIL order_w20 got=%b%b/%h/%h exp=10/20/1111", o_mem_write, o_mem_read, o_mem_addr, o_mem_wdata); else passed++;
        push_req(1'b1, 64'h60, 16'h2222, ok);
        push_req(1'b0, 64'h80, 16'h0, ok);
        total++; if (o_req_ready !== 1'b1) $display("FAIL order_ready_3q got=%b exp=1", o_req_ready); else passed++;
        push_req(1'b0, 64'hA0, 16'h0, ok);
        total++; if (o_req_ready !== 1'b0) $display("FAIL order_ready_4q got=%b exp=0", o_req_ready); else passed++;
        tick();
        total++; if ({o_mem_write, o_mem_read, o_mem_addr, o_mem_wdata} !== {2'b10, 64'h20, 16'h1111})
            $display("FAIL order_w20_held got=%b%b/%h/%h exp=10/20/1111", o_mem_write, o_mem_read, o_mem_addr, o_mem_wdata); else passed++;
        i_mem_ready = 1'b1;
        tick();
        total++; if ({o_mem_write, o_mem_read, o_mem_addr, o_req_ready} !== {2'b01, 64'h40, 1'b1})
            $display("FAIL order_r40 got=%b%b/%h rdy=%b exp=01/40 rdy=1", o_mem_write, o_mem_read, o_mem_addr, o_req_ready); else passed++;
        tick();
        total++; if ({o_mem_write, o_mem_read, o_mem_addr, o_mem_wdata} !== {2'b10, 64'h60, 16'h2222})
            $display("FAIL order_w60 got=%b%b/%h/%h exp=10/60/2222", o_mem_write, o_mem_read, o_mem_addr, o_mem_wdata); else passed++;
        tick();
        total++; if ({o_mem_write, o_mem_read, o_mem_addr} !== {2'b01, 64'h80})
            $display("FAIL order_r80 got=%b%b/%h exp=01/80", o_mem_write, o_mem_read, o_mem_addr); else passed++;
        tick();
        total++; if ({o_mem_write, o_mem_read, o_mem_addr} !== {2'b01, 64'hA0})
            $display("FAIL order_ra0 got=%b%b/%h exp=01/a0", o_mem_write, o_mem_read, o_mem_addr); else passed++;
        tick();
        total++; if ({o_mem_write, o_mem_read} !== 2'b00)
            $display("FAIL order_idle got=%b exp=00", {o_mem_write, o_mem_read}); else passed++;
        i_mem_ready = 1'b0;
        send_rdata(16'h00A1); send_rdata(16'h00A2); send_rdata(16'h00A3);
        i_resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_a = (k == 0) ? 64'h40 : (k == 1) ? 64'h80 : 64'hA0;
            total++; if ({o_resp_valid, o_resp_addr, o_resp_data} !== {1'b1, exp_a, 16'h00A1 + 16'(k)})
                $display("FAIL order_resp%0d got=%b/%h/%h exp=1/%h/%h", k, o_resp_valid, o_resp_addr, o_resp_data, exp_a, 16'h00A1 + 16'(k)); else passed++;
            tick();
        end
        i_resp_ready = 1'b0;
        total++; if ({o_resp_valid, o_busy} !== 2'b00)
            $display("FAIL order_drained got=%b exp=00", {o_resp_valid, o_busy}); else passed++;
    endtask

    task automatic test_credit_stall;
        bit ok;
        int base, sent, popped, n;
        i_mem_ready = 1'b1; i_resp_ready = 1'b0;
        base = acc_cnt;
        for (int k = 0; k < 6; k++) push_req(1'b0, 64'h100 + 64'(16 * k), 16'h0, ok);
        repeat (4) tick();
        total++; if (acc_cnt - base !== 4) $display("FAIL credit_cap got=%0d exp=4", acc_cnt - base); else passed++;
        total++; if ({o_mem_read, o_busy, o_resp_valid} !== 3'b010)
            $display("FAIL credit_blocked got=%b exp=010", {o_mem_read, o_busy, o_resp_valid}); else passed++;
        for (int k = 0; k < 4; k++) send_rdata(16'hD000 + 16'(k));
        total++; if ({o_resp_valid, o_resp_addr, o_resp_data} !== {1'b1, 64'h100, 16'hD000})
            $display("FAIL credit_head got=%b/%h/%h exp=1/100/d000", o_resp_valid, o_resp_addr, o_resp_data); else passed++;
        total++; if (acc_cnt - base !== 4) $display("FAIL credit_still_cap got=%0d exp=4", acc_cnt - base); else passed++;
        i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;
        total++; if (o_mem_read !== 1'b0) $display("FAIL credit_no_early_issue got=%b exp=0", o_mem_read); else passed++;
        tick();
        total++; if ({o_mem_read, o_mem_addr} !== {1'b1, 64'h140})
            $display("FAIL credit_fifth got=%b/%h exp=1/140", o_mem_read, o_mem_addr); else passed++;
        popped = 1; sent = 4; n = 0;
        i_resp_ready = 1'b1;
        while (popped < 6 && n < 200) begin
            if (acc_cnt - base > sent) begin
                i_mem_rvalid = 1'b1; i_mem_rdata = 16'hD000 + 16'(sent); sent++;
            end else i_mem_rvalid = 1'b0;
            if (o_resp_valid) begin
                total++; if ({o_resp_addr, o_resp_data} !== {64'h100 + 64'(16 * popped), 16'hD000 + 16'(popped)})
                    $display("FAIL credit_drain%0d got=%h/%h exp=%h/%h", popped, o_resp_addr, o_resp_data, 64'h100 + 64'(16 * popped), 16'hD000 + 16'(popped)); else passed++;
                popped++;
            end
            tick(); n++;
        end
        i_mem_rvalid = 1'b0; i_resp_ready = 1'b0;
        total++; if (popped !== 6 || acc_cnt - base !== 6 || o_err !== 1'b0)
            $display("FAIL credit_all got popped=%0d acc=%0d err=%b exp 6/6/0", popped, acc_cnt - base, o_err); else passed++;
    endtask

    task automatic test_backpressure;
        bit ok;
        int base, idx, cyc;
        logic rdy;
        i_mem_ready = 1'b1; i_resp_ready = 1'b0;
        base = acc_cnt;
        for (int k = 0; k < 4; k++) push_req(1'b0, 64'h200 + 64'(16 * k), 16'h0, ok);
        wait_acc(base + 4, ok);
        total++; if (ok !== 1'b1) $display("FAIL bp_issue_timeout got=%0d exp=4", acc_cnt - base); else passed++;
        for (int k = 0; k < 4; k++) send_rdata(16'hC000 + 16'(k));
        idx = 0; cyc = 0;
        while (idx < 4 && cyc < 20) begin
            rdy = cyc[0];
            i_resp_ready = rdy;
            total++; if ({o_resp_valid, o_resp_addr, o_resp_data} !== {1'b1, 64'h200 + 64'(16 * idx), 16'hC000 + 16'(idx)})
                $display("FAIL bp_head%0d got=%b/%h/%h exp=1/%h/%h", idx, o_resp_valid, o_resp_addr, o_resp_data, 64'h200 + 64'(16 * idx), 16'hC000 + 16'(idx)); else passed++;
            tick();
            if (rdy) idx++;
            cyc++;
        end
        i_resp_ready = 1'b0;
        total++; if ({o_resp_valid, o_busy} !== 2'b00)
            $display("FAIL bp_drained got=%b exp=00 idx=%0d", {o_resp_valid, o_busy}, idx); else passed++;
    endtask

    task automatic test_spurious;
        send_rdata(16'hDEAD);
        total++; if ({o_err, o_resp_valid} !== 2'b10)
            $display("FAIL spur_err got=%b exp=10", {o_err, o_resp_valid}); else passed++;
        repeat (3) tick();
        total++; if ({o_err, o_resp_valid, o_busy} !== 3'b100)
            $display("FAIL spur_sticky got=%b exp=100", {o_err, o_resp_valid, o_busy}); else passed++;
        i_nreset = 1'b0;
        #1;
        total++; if (o_err !== 1'b0) $display("FAIL spur_reset got=%b exp=0", o_err); else passed++;
        #1 i_nreset = 1'b1;
        tick();
    endtask

    task automatic test_reset_midflight;
        bit ok;
        int base;
        i_mem_ready = 1'b1; i_resp_ready = 1'b0;
        base = acc_cnt;
        push_req(1'b0, 64'h300, 16'h0, ok);
        push_req(1'b0, 64'h310, 16'h0, ok);
        wait_acc(base + 2, ok);
        i_mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_req(1'b0, 64'h320 + 64'(16 * k), 16'h0, ok);
        total++; if ({o_mem_read, o_busy} !== 2'b11) $display("FAIL mid_loaded got=%b exp=11", {o_mem_read, o_busy}); else passed++;
        #2 i_nreset = 1'b0;
        #1;
        total++; if ({o_req_ready, o_resp_valid, o_mem_read, o_mem_write, o_busy, o_err} !== 6'b100000)
            $display("FAIL mid_reset_flags got=%b exp=100000", {o_req_ready, o_resp_valid, o_mem_read, o_mem_write, o_busy, o_err}); else passed++;
        total++; if ({o_mem_addr, o_mem_wdata} !== 80'h0)
            $display("FAIL mid_reset_cmd got=%h exp=0", {o_mem_addr, o_mem_wdata}); else passed++;
        #3 i_nreset = 1'b1;
        tick();
        i_mem_ready = 1'b1;
        send_rdata(16'h5555);
        total++; if ({o_err, o_resp_valid} !== 2'b10)
            $display("FAIL mid_late_data got=%b exp=10", {o_err, o_resp_valid}); else passed++;
        i_nreset = 1'b0;
        #2 i_nreset = 1'b1;
        tick();
        base = acc_cnt;
        push_req(1'b0, 64'h3000, 16'h0, ok);
        wait_acc(base + 1, ok);
        total++; if (ok !== 1'b1) $display("FAIL mid_new_issue got=%0d exp=1", acc_cnt - base); else passed++;
        send_rdata(16'h1234);
        total++; if ({o_resp_valid, o_resp_addr, o_resp_data, o_err} !== {1'b1, 64'h3000, 16'h1234, 1'b0})
            $display("FAIL mid_new_resp got=%b/%h/%h err=%b exp=1/3000/1234 err=0", o_resp_valid, o_resp_addr, o_resp_data, o_err); else passed++;
        i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;
        total++; if ({o_resp_valid, o_busy} !== 2'b00)
            $display("FAIL mid_new_done got=%b exp=00", {o_resp_valid, o_busy}); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_fill();
        test_order();
        test_credit_stall();
        test_backpressure();
        test_spurious();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
